// File: rtl/game_pkg.sv
// Shared types and constants for the rhythm-game flow controller.
package game_pkg;

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_PLAY  = 3'd1,
    ST_PAUSE = 3'd2,
    ST_FAIL  = 3'd3,
    ST_CLEAR = 3'd4
  } state_e;

  localparam int unsigned SCORE_W = 14;
  localparam int unsigned COMBO_W = 8;

endpackage

// File: rtl/score_unit.sv
// Saturating score/combo datapath; a hit earns the level value plus one bonus point
// once the running combo has reached COMBO_STEP.
module score_unit
  import game_pkg::*;
#(
  parameter int unsigned SCORE_MAX  = 9999,
  parameter int unsigned COMBO_STEP = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               hit,
  input  logic               miss,
  input  logic [2:0]         level,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo
);

  localparam logic [SCORE_W:0]   ScoreMaxExt = (SCORE_W + 1)'(SCORE_MAX);
  localparam logic [COMBO_W-1:0] ComboMax    = '1;

  logic [SCORE_W-1:0] score_d, score_q;
  logic [COMBO_W-1:0] combo_d, combo_q;
  logic [SCORE_W:0]   sum;
  logic               bonus;

  always_comb begin
    score_d = score_q;
    combo_d = combo_q;
    // Bonus is judged on the combo before this hit (and before any same-cycle miss).
    bonus   = (combo_q >= COMBO_W'(COMBO_STEP));
    sum     = {1'b0, score_q} + (SCORE_W + 1)'(level) + (SCORE_W + 1)'(bonus);
    if (clr) begin
      score_d = '0;
      combo_d = '0;
    end else begin
      if (hit) begin
        score_d = (sum > ScoreMaxExt) ? SCORE_W'(SCORE_MAX) : sum[SCORE_W-1:0];
        if (combo_q != ComboMax) combo_d = combo_q + COMBO_W'(1);
      end
      if (miss) combo_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_q <= '0;
      combo_q <= '0;
    end else begin
      score_q <= score_d;
      combo_q <= combo_d;
    end
  end

  assign score = score_q;
  assign combo = combo_q;

endmodule

// File: rtl/game_ctrl.sv
// Top-level game flow: state machine, level latch, life thermometer and script control,
// with the score/combo datapath delegated to score_unit.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned NUM_LEVELS = 4,
  parameter int unsigned LIFE_MAX   = 10,
  parameter int unsigned SCORE_MAX  = 9999,
  parameter int unsigned COMBO_STEP = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                level_valid,
  input  logic [2:0]          level_sel,
  input  logic                hit,
  input  logic                damage,
  input  logic                chart_end,
  input  logic                pause_req,
  input  logic                return_req,
  output logic [2:0]          state,
  output logic [2:0]          level,
  output logic                chart_start,
  output logic                chart_hold,
  output logic [LIFE_MAX-1:0] life_led,
  output logic [SCORE_W-1:0]  score,
  output logic [COMBO_W-1:0]  combo
);

  localparam logic [LIFE_MAX-1:0] LifeFull = '1;
  localparam logic [LIFE_MAX-1:0] LifeOne  = LIFE_MAX'(1);

  state_e              state_q, state_d;
  logic [2:0]          level_q, level_d;
  logic                chart_start_q, chart_start_d;
  logic                chart_hold_q, chart_hold_d;
  // Life is kept directly as its thermometer; losing a life is a right shift.
  logic [LIFE_MAX-1:0] life_q, life_d;
  logic                play_hit, play_dmg, sel_ok, last_life, clr;

  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    life_d        = life_q;
    chart_start_d = 1'b0;
    play_hit      = 1'b0;
    play_dmg      = 1'b0;
    sel_ok        = (level_sel != 3'd0) && (32'(level_sel) <= NUM_LEVELS);
    last_life     = (life_q == LifeOne);

    unique case (state_q)
      ST_START: begin
        if (level_valid && sel_ok) begin
          state_d       = ST_PLAY;
          level_d       = level_sel;
          chart_start_d = 1'b1;
        end
      end
      ST_PLAY: begin
        play_hit = hit;
        play_dmg = damage;
        if (damage) life_d = life_q >> 1;
        if (damage && last_life) state_d = ST_FAIL;
        else if (chart_end)      state_d = ST_CLEAR;
        else if (pause_req)      state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        // Leaving the game wins over resuming when both arrive together.
        if (return_req)     state_d = ST_START;
        else if (pause_req) state_d = ST_PLAY;
      end
      ST_FAIL, ST_CLEAR: begin
        if (return_req) state_d = ST_START;
      end
      default: state_d = ST_START;
    endcase

    clr = (state_d == ST_START);
    if (clr) begin
      level_d = '0;
      life_d  = LifeFull;
    end
    chart_hold_d = (state_d == ST_PAUSE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_START;
      level_q       <= '0;
      chart_start_q <= 1'b0;
      chart_hold_q  <= 1'b0;
      life_q        <= LifeFull;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      chart_start_q <= chart_start_d;
      chart_hold_q  <= chart_hold_d;
      life_q        <= life_d;
    end
  end

  score_unit #(
    .SCORE_MAX  (SCORE_MAX),
    .COMBO_STEP (COMBO_STEP)
  ) u_score (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .hit   (play_hit),
    .miss  (play_dmg),
    .level (level_q),
    .score (score),
    .combo (combo)
  );

  assign state       = state_q;
  assign level       = level_q;
  assign chart_start = chart_start_q;
  assign chart_hold  = chart_hold_q;
  assign life_led    = life_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed table, hand-written corner sequences and
// randomized traffic compared against a behavioural model of the game rules.
module tb_game_ctrl;

  localparam int NL = 4;
  localparam int LM = 10;
  localparam int SM = 9999;
  localparam int CS = 10;

  localparam int M_START = 0;
  localparam int M_PLAY  = 1;
  localparam int M_PAUSE = 2;
  localparam int M_FAIL  = 3;
  localparam int M_CLEAR = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          level_valid = 1'b0;
  logic [2:0]    level_sel = 3'd0;
  logic          hit = 1'b0, damage = 1'b0, chart_end = 1'b0;
  logic          pause_req = 1'b0, return_req = 1'b0;
  logic [2:0]    state, level;
  logic          chart_start, chart_hold;
  logic [LM-1:0] life_led;
  logic [13:0]   score;
  logic [7:0]    combo;

  game_ctrl #(
    .NUM_LEVELS (NL),
    .LIFE_MAX   (LM),
    .SCORE_MAX  (SM),
    .COMBO_STEP (CS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .level_valid (level_valid),
    .level_sel   (level_sel),
    .hit         (hit),
    .damage      (damage),
    .chart_end   (chart_end),
    .pause_req   (pause_req),
    .return_req  (return_req),
    .state       (state),
    .level       (level),
    .chart_start (chart_start),
    .chart_hold  (chart_hold),
    .life_led    (life_led),
    .score       (score),
    .combo       (combo)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model of the game rules
  int m_state, m_level, m_life, m_score, m_combo, m_cs;

  task automatic model_reset();
    m_state = M_START;
    m_level = 0;
    m_life  = LM;
    m_score = 0;
    m_combo = 0;
    m_cs    = 0;
  endtask

  task automatic model_step(input int lv, input int sel, input int h, input int d,
                            input int ce, input int pr, input int rr);
    int prev_life;
    prev_life = m_life;
    m_cs = 0;
    case (m_state)
      M_START: begin
        if (lv != 0 && sel >= 1 && sel <= NL) begin
          m_state = M_PLAY;
          m_level = sel;
          m_cs    = 1;
        end
      end
      M_PLAY: begin
        if (h != 0) begin
          m_score = m_score + m_level + ((m_combo >= CS) ? 1 : 0);
          if (m_score > SM) m_score = SM;
          if (m_combo < 255) m_combo = m_combo + 1;
        end
        if (d != 0) begin
          m_combo = 0;
          m_life  = m_life - 1;
        end
        if (d != 0 && prev_life == 1) m_state = M_FAIL;
        else if (ce != 0)             m_state = M_CLEAR;
        else if (pr != 0)             m_state = M_PAUSE;
      end
      M_PAUSE: begin
        if (rr != 0)      model_reset();
        else if (pr != 0) m_state = M_PLAY;
      end
      default: begin
        if (rr != 0) model_reset();
      end
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("state",       32'(state),       32'(m_state));
    chk("level",       32'(level),       32'(m_level));
    chk("chart_start", 32'(chart_start), 32'(m_cs));
    chk("chart_hold",  32'(chart_hold),  (m_state == M_PAUSE) ? 32'd1 : 32'd0);
    chk("life_led",    32'(life_led),    (32'd1 << m_life) - 32'd1);
    chk("score",       32'(score),       32'(m_score));
    chk("combo",       32'(combo),       32'(m_combo));
  endtask

  // One clock: drive inputs, clock, advance model, sample 1 time unit after the edge.
  task automatic step(input int lv, input int sel, input int h, input int d,
                      input int ce, input int pr, input int rr);
    level_valid = 1'(lv);
    level_sel   = 3'(sel);
    hit         = 1'(h);
    damage      = 1'(d);
    chart_end   = 1'(ce);
    pause_req   = 1'(pr);
    return_req  = 1'(rr);
    @(posedge clk);
    model_step(lv, sel, h, d, ce, pr, rr);
    #1;
    level_valid = 1'b0;
    hit         = 1'b0;
    damage      = 1'b0;
    chart_end   = 1'b0;
    pause_req   = 1'b0;
    return_req  = 1'b0;
    check_all();
  endtask

  typedef struct {
    int lv, sel, h, d, ce, pr, rr;
    int e_state, e_level, e_cs, e_hold;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int guard;
    model_reset();

    // Reset state
    #12;
    check_all();
    chk("reset_life", 32'(life_led), 32'h3FF);
    @(posedge clk);
    #1 rst = 1'b1;

    //            lv sel h  d  ce pr rr   state    lvl cs hold
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0,  M_START, 0, 0, 0});
    tbl.push_back('{1, 5, 0, 0, 0, 0, 0,  M_START, 0, 0, 0});
    tbl.push_back('{1, 2, 0, 0, 0, 0, 0,  M_PLAY,  2, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0,  M_PLAY,  2, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 0,  M_PLAY,  2, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 0,  M_PAUSE, 2, 0, 1});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 0,  M_PAUSE, 2, 0, 1});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0,  M_PAUSE, 2, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 0,  M_PAUSE, 2, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 0,  M_PLAY,  2, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1,  M_PLAY,  2, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 0,  M_PAUSE, 2, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1,  M_START, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1,  M_START, 0, 0, 0});

    foreach (tbl[i]) begin
      step(tbl[i].lv, tbl[i].sel, tbl[i].h, tbl[i].d, tbl[i].ce, tbl[i].pr, tbl[i].rr);
      chk($sformatf("tbl%0d_state", i), 32'(state),       32'(tbl[i].e_state));
      chk($sformatf("tbl%0d_level", i), 32'(level),       32'(tbl[i].e_level));
      chk($sformatf("tbl%0d_cs", i),    32'(chart_start), 32'(tbl[i].e_cs));
      chk($sformatf("tbl%0d_hold", i),  32'(chart_hold),  32'(tbl[i].e_hold));
    end

    // Level 3, twelve hits: ten plain, two with bonus
    step(1, 3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 0, 0, 0);
    chk("l3_combo", 32'(combo), 32'd12);
    chk("l3_score", 32'(score), 32'd38);

    // Ten damage pulses drain life and fail on the last
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 1, 0, 0, 0);
      chk($sformatf("drain%0d_life", i), 32'(life_led), (32'd1 << (9 - i)) - 32'd1);
    end
    chk("drain_fail", 32'(state), 32'(M_FAIL));
    chk("drain_combo", 32'(combo), 32'd0);
    step(0, 0, 1, 0, 1, 1, 0);
    chk("fail_hold_score", 32'(score), 32'd38);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("ret_state", 32'(state), 32'(M_START));
    chk("ret_life", 32'(life_led), 32'h3FF);
    chk("ret_score", 32'(score), 32'd0);

    // Last-life damage together with chart_end: fail wins
    step(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    chk("fail_vs_clear", 32'(state), 32'(M_FAIL));
    step(0, 0, 0, 0, 0, 0, 1);

    // Clear path
    step(1, 4, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 0, 0);
    chk("clear_state", 32'(state), 32'(M_CLEAR));
    step(0, 0, 0, 0, 0, 0, 1);

    // Score and combo saturation at level 4
    step(1, 4, 0, 0, 0, 0, 0);
    guard = 0;
    while (m_score < SM && guard < 3000) begin
      step(0, 0, 1, 0, 0, 0, 0);
      guard++;
    end
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("sat_score", 32'(score), 32'd9999);
    chk("sat_combo", 32'(combo), 32'd255);

    // Asynchronous reset mid-play takes effect without a clock edge
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_life", 32'(life_led), 32'h3FF);
    chk("arst_score", 32'(score), 32'd0);
    check_all();
    @(posedge clk);
    #1 rst = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 7) == 0) ? 1 : 0,
           int'($urandom_range(0, 7)),
           ($urandom_range(0, 1) == 0) ? 1 : 0,
           ($urandom_range(0, 15) == 0) ? 1 : 0,
           ($urandom_range(0, 63) == 0) ? 1 : 0,
           ($urandom_range(0, 31) == 0) ? 1 : 0,
           ($urandom_range(0, 15) == 0) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
